// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: FSM state encoding, protocol durations in units, and the mark-state helper.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        REP_SPACE  = 3'd5,
        STOP_MARK  = 3'd6,
        GAP        = 3'd7
    } ir_state_e;

    localparam int LEAD_MARK_UNITS  = 16;
    localparam int LEAD_SPACE_UNITS = 8;
    localparam int REP_SPACE_UNITS  = 4;
    localparam int ZERO_SPACE_UNITS = 1;
    localparam int ONE_SPACE_UNITS  = 3;
    localparam int STOP_UNITS       = 1;
    localparam int FRAME_BITS       = 32;

    function automatic logic is_mark(input ir_state_e s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier: phase high for CARRIER_HALF clocks, then low, restartable at each mark entry.
module ir_carrier_gen #(
    parameter int CARRIER_HALF = 658
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase
);

    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Next-state logic: restart forces the high half to begin on the following clock
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = CW'(0);
            phase_d = 1'b1;
        end else if (cnt_q == CW'(CARRIER_HALF - 1)) begin
            cnt_d   = CW'(0);
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            phase_d = phase_q;
        end
    end

    // Carrier registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= CW'(0);
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: frames {~cmd,cmd,~addr,addr} LSB first, followed by an idle gap.
// Optional repeat codes are enabled with the IR_NEC_TX_REPEAT_EN macro.
module ir_nec_tx
    import ir_pkg::*;
#(
    parameter int UNIT_CLKS    = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int GAP_UNITS    = 72
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
`ifdef IR_NEC_TX_REPEAT_EN
    input  logic       repeatSend,
`endif
    output logic       busy,
    output logic       done,
    output logic       irEnv,
    output logic       irOut
);

    localparam int UCW     = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
    localparam int DUR_MAX = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
    localparam int DW      = $clog2(DUR_MAX) + 1;

    ir_state_e      state_q, state_d;
    logic [UCW-1:0] unit_q, unit_d;
    logic [DW-1:0]  units_q, units_d;
    logic [5:0]     bit_q, bit_d;
    logic [31:0]    shift_q, shift_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           env_q, env_d;
`ifdef IR_NEC_TX_REPEAT_EN
    logic           rep_q, rep_d;
    logic           sent_q, sent_d;
`endif

    logic [DW-1:0]  dur_s;
    logic           unit_wrap_s;
    logic           last_unit_s;
    logic           step_s;
    logic           restart_s;
    logic           phase_s;

    // Duration of the current state in units; a bit space depends on the bit being sent
    always_comb begin
        dur_s = DW'(1);
        case (state_q)
            LEAD_MARK:  dur_s = DW'(LEAD_MARK_UNITS);
            LEAD_SPACE: dur_s = DW'(LEAD_SPACE_UNITS);
            BIT_MARK:   dur_s = DW'(1);
            BIT_SPACE:  dur_s = shift_q[0] ? DW'(ONE_SPACE_UNITS) : DW'(ZERO_SPACE_UNITS);
            REP_SPACE:  dur_s = DW'(REP_SPACE_UNITS);
            STOP_MARK:  dur_s = DW'(STOP_UNITS);
            GAP:        dur_s = DW'(GAP_UNITS);
            default:    dur_s = DW'(1);
        endcase
    end

    assign unit_wrap_s = (unit_q == UCW'(UNIT_CLKS - 1));
    assign last_unit_s = (units_q == (dur_s - DW'(1)));
    assign step_s      = unit_wrap_s && last_unit_s;

    // FSM next-state, counters and registered-output values
    always_comb begin
        state_d = state_q;
        unit_d  = unit_q;
        units_d = units_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef IR_NEC_TX_REPEAT_EN
        rep_d   = rep_q;
        sent_d  = sent_q;
`endif
        if (state_q == IDLE) begin
            unit_d  = UCW'(0);
            units_d = DW'(0);
            if (send) begin
                state_d = LEAD_MARK;
                shift_d = {~cmd, cmd, ~addr, addr};
                bit_d   = 6'd0;
`ifdef IR_NEC_TX_REPEAT_EN
                rep_d   = 1'b0;
            end else if (repeatSend && sent_q) begin
                state_d = LEAD_MARK;
                rep_d   = 1'b1;
`endif
            end else begin
                state_d = IDLE;
            end
        end else begin
            unit_d = unit_wrap_s ? UCW'(0) : unit_q + UCW'(1);
            if (unit_wrap_s) begin
                units_d = last_unit_s ? DW'(0) : units_q + DW'(1);
            end else begin
                units_d = units_q;
            end
            if (step_s) begin
                case (state_q)
                    LEAD_MARK: begin
`ifdef IR_NEC_TX_REPEAT_EN
                        state_d = rep_q ? REP_SPACE : LEAD_SPACE;
`else
                        state_d = LEAD_SPACE;
`endif
                    end
                    LEAD_SPACE: state_d = BIT_MARK;
                    BIT_MARK:   state_d = BIT_SPACE;
                    BIT_SPACE: begin
                        shift_d = shift_q >> 1;
                        if (bit_q == 6'(FRAME_BITS - 1)) begin
                            bit_d   = 6'd0;
                            state_d = STOP_MARK;
                        end else begin
                            bit_d   = bit_q + 6'd1;
                            state_d = BIT_MARK;
                        end
                    end
                    REP_SPACE:  state_d = STOP_MARK;
                    STOP_MARK:  state_d = GAP;
                    GAP: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
`ifdef IR_NEC_TX_REPEAT_EN
                        sent_d  = 1'b1;
`endif
                    end
                    default:    state_d = IDLE;
                endcase
            end else begin
                state_d = state_q;
            end
        end
    end

    assign busy_d    = (state_d != IDLE);
    assign env_d     = is_mark(state_d);
    assign restart_s = is_mark(state_d) && !is_mark(state_q);

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            unit_q  <= UCW'(0);
            units_q <= DW'(0);
            bit_q   <= 6'd0;
            shift_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            env_q   <= 1'b0;
`ifdef IR_NEC_TX_REPEAT_EN
            rep_q   <= 1'b0;
            sent_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            units_q <= units_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            env_q   <= env_d;
`ifdef IR_NEC_TX_REPEAT_EN
            rep_q   <= rep_d;
            sent_q  <= sent_d;
`endif
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .clk    (clk),
        .rst    (rst),
        .restart(restart_s),
        .phase  (phase_s)
    );

    assign busy  = busy_q;
    assign done  = done_q;
    assign irEnv = env_q;
    assign irOut = env_q & phase_s;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: expected envelope segment lists queued per request, checked by a monitor on each done.
module tb_ir_nec_tx;

    localparam int U  = 8;
    localparam int CH = 2;
    localparam int GU = 4;
    localparam int TO = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] addr = 8'd0;
    logic [7:0] cmd = 8'd0;
`ifdef IR_NEC_TX_REPEAT_EN
    logic       repeatSend = 1'b0;
`endif
    logic       busy, done, irEnv, irOut;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_q[$];

    int   runs[$];
    int   run_len = 0;
    int   busy_len = 0;
    int   carrier_err = 0;
    logic cur_lvl = 1'b0;
    logic prev_done = 1'b0;

    ir_nec_tx #(
        .UNIT_CLKS(U),
        .CARRIER_HALF(CH),
        .GAP_UNITS(GU)
    ) dut (
        .clk(clk),
        .rst(rst),
        .send(send),
        .addr(addr),
        .cmd(cmd),
`ifdef IR_NEC_TX_REPEAT_EN
        .repeatSend(repeatSend),
`endif
        .busy(busy),
        .done(done),
        .irEnv(irEnv),
        .irOut(irOut)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, expv);
        end
    endfunction

    // Expected entry: segment count, busy length, then signed runs (+mark / -space)
    task automatic push_exp(input int s[$]);
        int b;
        b = 0;
        foreach (s[i]) b += (s[i] < 0) ? -s[i] : s[i];
        exp_q.push_back(s.size());
        exp_q.push_back(b);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] c);
        logic [31:0] w;
        int s[$];
        w = {~c, c, ~a, a};
        s.push_back(16 * U);
        s.push_back(-8 * U);
        for (int i = 0; i < 32; i++) begin
            s.push_back(U);
            s.push_back(w[i] ? -3 * U : -U);
        end
        s.push_back(U);
        s.push_back(-GU * U);
        push_exp(s);
    endtask

    task automatic push_repeat();
        int s[$];
        s.push_back(16 * U);
        s.push_back(-4 * U);
        s.push_back(U);
        s.push_back(-GU * U);
        push_exp(s);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c);
        @(negedge clk);
        addr = a;
        cmd  = c;
        send = 1'b1;
        push_frame(a, c);
        @(negedge clk);
        send = 1'b0;
        addr = 8'($urandom);
        cmd  = 8'($urandom);
    endtask

    task automatic wait_done(input string name);
        int start;
        start = done_cnt;
        for (int i = 0; i < TO && done_cnt == start; i++) @(posedge clk);
        check(name, done_cnt - start, 1);
        @(negedge clk);
    endtask

    // Monitor: measure envelope runs and carrier while busy; compare against the queue on done
    always @(negedge clk) begin : mon
        int n, b, e;
        if (!rst) begin
            check("done_in_reset", int'(done), 0);
            runs.delete();
            run_len = 0;
            busy_len = 0;
            carrier_err = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                check("done_width", int'(prev_done), 0);
                check("busy_at_done", int'(busy), 0);
                if (run_len > 0) runs.push_back(cur_lvl ? run_len : -run_len);
                check("expected_frame_pending", (exp_q.size() >= 2) ? 1 : 0, 1);
                if (exp_q.size() >= 2) begin
                    n = exp_q.pop_front();
                    b = exp_q.pop_front();
                    check("seg_count", runs.size(), n);
                    check("busy_len", busy_len, b);
                    for (int i = 0; i < n; i++) begin
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                        check($sformatf("seg%0d", i), (i < runs.size()) ? runs[i] : 0, e);
                    end
                    check("carrier_err", carrier_err, 0);
                end
                runs.delete();
                run_len = 0;
                busy_len = 0;
                carrier_err = 0;
            end else if (busy) begin
                busy_len++;
                if (run_len > 0 && irEnv == cur_lvl) begin
                    run_len++;
                end else begin
                    if (run_len > 0) runs.push_back(cur_lvl ? run_len : -run_len);
                    cur_lvl = irEnv;
                    run_len = 1;
                end
                if (irOut !== (irEnv && ((((run_len - 1) / CH) % 2) == 0))) carrier_err++;
            end else begin
                check("idle_outputs", int'({irEnv, irOut}), 0);
            end
            prev_done = done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_env", int'(irEnv), 0);
        check("rst_out", int'(irOut), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

`ifdef IR_NEC_TX_REPEAT_EN
        @(negedge clk);
        repeatSend = 1'b1;
        @(negedge clk);
        repeatSend = 1'b0;
        repeat (20) @(negedge clk);
        check("rep_before_frame_busy", int'(busy), 0);
`endif

        send_frame(8'h00, 8'h16);
        wait_done("done_basic");

        // Requests during a frame must be ignored
        send_frame(8'($urandom), 8'($urandom));
        repeat (9) @(negedge clk);
        addr = 8'($urandom);
        cmd  = 8'($urandom);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (489) @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_done("done_ignored_sends");
        repeat (40) @(negedge clk);
        check("no_extra_frame_busy", int'(busy), 0);

        for (int k = 0; k < 3; k++) begin
            send_frame(8'($urandom), 8'($urandom));
            wait_done("done_random");
        end

        // send held across done: next frame must start on the done cycle
        @(negedge clk);
        addr = 8'($urandom);
        cmd  = 8'($urandom);
        push_frame(addr, cmd);
        push_frame(addr, cmd);
        send = 1'b1;
        start = done_cnt;
        for (int i = 0; i < TO && done_cnt == start; i++) @(posedge clk);
        check("b2b_first_done", done_cnt - start, 1);
        #1;
        check("b2b_no_idle_busy", int'(busy), 1);
        send = 1'b0;
        wait_done("done_b2b_second");

        // Asynchronous reset mid-frame
        send_frame(8'($urandom), 8'($urandom));
        repeat (300) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_env", int'(irEnv), 0);
        check("midrst_out", int'(irOut), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send_frame(8'h00, 8'h16);
        wait_done("done_after_reset");

`ifdef IR_NEC_TX_REPEAT_EN
        @(negedge clk);
        repeatSend = 1'b1;
        push_repeat();
        @(negedge clk);
        repeatSend = 1'b0;
        wait_done("done_repeat");

        @(negedge clk);
        addr = 8'($urandom);
        cmd  = 8'($urandom);
        send = 1'b1;
        repeatSend = 1'b1;
        push_frame(addr, cmd);
        @(negedge clk);
        send = 1'b0;
        repeatSend = 1'b0;
        wait_done("done_send_wins");

        @(negedge clk);
        repeatSend = 1'b1;
        push_repeat();
        @(negedge clk);
        repeatSend = 1'b0;
        wait_done("done_repeat_again");
`endif

        repeat (20) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_nec_tx.md
Name: ir_nec_tx

Overview:
NEC-protocol infrared transmitter. It is the transmit-side counterpart of the IR receiver that feeds the CPU's irIrq/irData path. A CPU-side or bench-side master latches an 8-bit address and an 8-bit command, and the block produces a 38 kHz-modulated NEC frame on irOut for an IR LED, plus the unmodulated envelope on irEnv for loopback into the receiver.

Parameters:
UNIT_CLKS, 28125, clocks per NEC unit (562.5 us at 50 MHz)
CARRIER_HALF, 658, clocks per carrier half-period (about 38 kHz at 50 MHz)
GAP_UNITS, 72, idle units enforced after every frame before busy drops

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
send  in  1  request a full frame; accepted only when busy=0
addr  in  8  NEC address, latched on acceptance
cmd  in  8  NEC command, latched on acceptance
busy  out  1  frame or gap in progress
done  out  1  one-cycle pulse when a frame (including its gap) completes
irEnv  out  1  unmodulated envelope, 1 = mark
irOut  out  1  modulated LED drive, irEnv AND carrier

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy, done, irEnv and irOut are 0 immediately; bit counter, unit counter and carrier counter are 0; the "frame sent" flag is cleared. Reset mid-frame aborts the frame with no done pulse.
- Acceptance: send=1 and busy=0 at edge N.
  - addr and cmd are latched into a 32-bit shift word {~cmd, cmd, ~addr, addr}, sent LSB first.
  - busy=1 and irEnv=1 from N+1.
  - send while busy=1 is ignored; input changes after acceptance have no effect.
- States and durations, in units of UNIT_CLKS clocks:
  - IDLE
  - LEAD_MARK: 16 units, envelope 1
  - LEAD_SPACE: 8 units, envelope 0
  - BIT_MARK: 1 unit, envelope 1
  - BIT_SPACE: 1 unit for bit 0, 3 units for bit 1, envelope 0
  - After BIT_SPACE: loop to BIT_MARK for 32 bits, then go to STOP_MARK.
  - STOP_MARK: 1 unit, envelope 1
  - GAP: GAP_UNITS units, envelope 0
  - GAP then returns to IDLE.
- Frame length: a full frame is always 121 units of envelope plus the gap, because the complement bytes guarantee 16 ones and 16 zeros.
- Completion: on the cycle after the last GAP clock, busy=0 and done=1 for exactly one cycle. A send in that same cycle is accepted, so back-to-back frames are possible.
- Carrier:
  - The counter restarts at 0 on entry to every mark state.
  - The phase is high for the first CARRIER_HALF clocks, then low for CARRIER_HALF clocks, repeating.
  - irOut = irEnv & phase, so irOut=0 throughout every space and in IDLE.
- Counters: the unit counter runs 0..UNIT_CLKS-1 and wraps on each unit boundary; the bit counter is 6 bits and runs 0..31. All state transitions happen on unit-counter wrap.
- Successful completion of a full frame sets the "frame sent" flag.

Optional Feature:
Macro IR_NEC_TX_REPEAT_EN.
- With the macro: extra input repeatSend (1 bit) and extra state REP_SPACE.
  - repeatSend=1, busy=0 and "frame sent"=1 starts a repeat code: LEAD_MARK 16 units, REP_SPACE 4 units, STOP_MARK 1 unit, then GAP, then done.
  - repeatSend with "frame sent"=0 is ignored.
  - If send and repeatSend are asserted together, send wins.
- Without the macro: no repeatSend port and no REP_SPACE state. Frames only.

Decomposition:
- Package ir_pkg holds:
  - the state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REP_SPACE, STOP_MARK, GAP)
  - unit constants LEAD_MARK_UNITS=16, LEAD_SPACE_UNITS=8, REP_SPACE_UNITS=4, ZERO_SPACE_UNITS=1, ONE_SPACE_UNITS=3, STOP_UNITS=1, FRAME_BITS=32
  - this package is shared with the IR receiver.
- Sub-module ir_carrier_gen:
  - parameter CARRIER_HALF
  - inputs clk, rst, restart
  - output phase

Test Plan (UNIT_CLKS=8, CARRIER_HALF=2, GAP_UNITS=4):
- Reset: hold rst=0 mid-frame -> irOut, irEnv, busy, done go to 0 without waiting for a clock edge; release, then send addr=0x00 cmd=0x16 -> clean new frame starting with a 128-clock mark.
- Frame encoding: addr=0x00 cmd=0x16 -> envelope shows mark 128 / space 64, then bits of 0xE916FF00 LSB first. The first 8 bits are mark 8 / space 8 each; the 0xFF byte bits are mark 8 / space 24. Total envelope 968 clocks, busy high exactly 1000 clocks, one done pulse.
- Carrier: during each mark irOut = 1,1,0,0,... starting high at the mark's first clock; irOut=0 during every space and the gap.
- Handshake: send pulses at +10 and +500 clocks into a frame -> ignored, exactly one frame. send held high across done -> second frame starts on the done cycle with no idle clock.
- Repeat (macro on): repeatSend right after reset -> ignored. After a frame, repeatSend -> mark 128 / space 32 / mark 8, busy 200 clocks, one done. Macro off: the same bench without repeatSend compiles and passes the other scenarios.
